dpram_stream_reader: RTL
========================

Name: dpram_stream_reader

Overview:
- Read-side master for one port of the team's true dual-port RAM (registered read, 1-cycle latency).
- On a start command it reads `len` consecutive words from `base_addr` and presents them on a valid/ready stream.
- A 2-entry output FIFO absorbs the RAM read latency. Full throughput is 1 word/cycle under continuous `out_ready`; backpressure loses no data.
- Typical use: vector/frame RAM scan-out, while the CPU writes the other RAM port.

Parameters:
- ADDR_WIDTH, 15, RAM address width; matches the RAM instance.
- DATA_WIDTH, 8, RAM word width.

Ports:
- clock  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first word address; captured with start.
- len  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; captured with start.
- abort  input  1  synchronous cancel of the current transfer.
- busy  output  1  transfer in progress.
- done  output  1  1-cycle pulse at normal completion.
- ram_address  output  ADDR_WIDTH  to the RAM port address input.
- ram_wren  output  1  to the RAM port write enable; tied 0.
- ram_data  output  DATA_WIDTH  to the RAM port data input; tied 0.
- ram_q  input  DATA_WIDTH  from the RAM port q output.
- out_data  output  DATA_WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from the consumer.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_data=0, ram_address=0. FIFO empty, in-flight flag clear, state IDLE. Reset overrides start and abort in the same cycle.
- States:
  - IDLE -> RUN: start=1 and len!=0. Capture base_addr into the pointer and len into the remaining-issue and remaining-deliver counters.
  - IDLE, start with len=0: no RAM reads, busy stays 0, done=1 on the next cycle, stay IDLE.
  - RUN -> IDLE: the handshake (out_valid & out_ready) on the final word. done=1 in the following cycle.
- busy=1 in every cycle the state is RUN. busy=0 in the cycle done pulses.
- Read issue:
  - ram_address = pointer register, combinational.
  - A read issues in a RUN cycle when remaining_issue>0 and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
  - On issue: pointer increments, remaining_issue decrements, inflight is set for the next cycle.
  - ram_q is written into the FIFO in the cycle after the issue.
- Pointer wraps modulo 2^ADDR_WIDTH (all-ones -> 0). No error on wrap.
- FIFO: 2 entries, registered output. out_valid = FIFO non-empty; out_data = head entry. Simultaneous push and pop is legal in any occupancy.
- Stream rules:
  - out_data holds stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake, except on abort or reset.
- Latency: with start at cycle 0, the first read issues in cycle 1 and out_valid first rises in cycle 3. With out_ready held 1, one word is delivered per cycle and done pulses at cycle len+3.
- start while in RUN is ignored; captured values are unaffected.
- abort in RUN: next cycle the state is IDLE, the FIFO is flushed, out_valid=0, and in-flight read data is discarded. No done pulse. abort in IDLE has no effect.
- ram_wren and ram_data are constant 0; the block never writes the RAM.

Test Plan:
- Basic: RAM preloaded with mem[i]=i[7:0]; start base=0x0010 len=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on cycles 3..6; done pulse at cycle 7; busy high cycles 1..6.
- Backpressure: len=8; out_ready toggles 1,0,0,1 repeating -> all 8 words in order, none duplicated or lost; out_data stable during every stall; ram_address never runs more than 2 words ahead of the last accepted word.
- Wrap: base=0x7FFE len=4 -> ram_address sequence 7FFE, 7FFF, 0000, 0001; data mem[7FFE], mem[7FFF], mem[0], mem[1].
- Zero length and ignored start: start len=0 -> done pulse next cycle, busy=0, no change on ram_address. start pulsed mid-RUN -> original transfer completes unaltered.
- Abort: len=16; abort after 5 handshakes -> next cycle out_valid=0, busy=0, no done. A new start base=0x0100 len=2 then delivers mem[100], mem[101] with no stale words.
- Reset: assert reset during RUN with out_valid=1 -> next cycle all outputs at reset values. The first transfer after reset behaves identically to the Basic test.

Source files
------------

// File: rtl/dpram_stream_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dpram_stream_reader : streams len words from one port of a registered-read
// dual-port RAM onto a valid/ready interface through a 2-entry FIFO.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dpram_stream_reader #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_wren,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_ptr_one = 1;
  localparam logic [ADDR_WIDTH:0]   c_cnt_one = 1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_rem_issue;
  logic [ADDR_WIDTH:0]   r_rem_deliver;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_rd_idx;
  logic                  r_wr_idx;
  logic [1:0]            r_count;
  logic                  r_done;

  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic       w_last;
  logic [2:0] w_occ;

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_inflight;
  // Occupancy after this cycle's pop, counting the read still in the RAM pipe.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && !abort && (r_rem_issue != '0) && (w_occ < 3'd2);
  assign w_last  = w_pop && (r_rem_deliver == c_cnt_one);

  assign busy        = (r_state == S_RUN);
  assign done        = r_done;
  assign ram_address = r_ptr;
  assign ram_wren    = 1'b0;
  assign ram_data    = '0;
  assign out_valid   = (r_count != 2'd0);
  assign out_data    = r_fifo[r_rd_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_rem_issue   <= '0;
      r_rem_deliver <= '0;
      r_inflight    <= 1'b0;
      r_fifo[0]     <= '0;
      r_fifo[1]     <= '0;
      r_rd_idx      <= 1'b0;
      r_wr_idx      <= 1'b0;
      r_count       <= 2'd0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state       <= S_RUN;
              r_ptr         <= base_addr;
              r_rem_issue   <= len;
              r_rem_deliver <= len;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            // Flush everything, including the read still returning from the RAM.
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_rd_idx   <= 1'b0;
            r_wr_idx   <= 1'b0;
          end else begin
            if (w_issue) begin
              r_ptr       <= r_ptr + c_ptr_one;
              r_rem_issue <= r_rem_issue - c_cnt_one;
            end
            r_inflight <= w_issue;
            if (w_push) begin
              r_fifo[r_wr_idx] <= ram_q;
              r_wr_idx         <= ~r_wr_idx;
            end
            if (w_pop) begin
              r_rd_idx      <= ~r_rd_idx;
              r_rem_deliver <= r_rem_deliver - c_cnt_one;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
